// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences byte-wide RAM transfers for MEM-stage loads/stores, returns extended load data.
// Optional misalignment trap when MEM_CTRL_ALIGN_CHK_EN is defined.
module mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
    localparam logic [2:0] LAT = 3'(RAM_RD_LAT);
    state_t state;
    logic [31:0] wd_q, rbuf, ld_bytes, ld_val;
    logic [2:0] n_q, icnt, rcnt, t, n_in;
    logic sx_q;
    assign n_in = size_i == 2'b00 ? 3'd1 : size_i == 2'b01 ? 3'd2 : 3'd4;
`ifdef MEM_CTRL_ALIGN_CHK_EN
    logic mis;
    assign mis = (size_i == 2'b01 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
`else
    assign err_o = 1'b0;
`endif
    // the byte arriving this cycle is merged in so the final byte can complete the word directly
    always_comb begin
        ld_bytes = rbuf;
        ld_bytes[{rcnt[1:0], 3'b000} +: 8] = mem_din;
        ld_val = n_q == 3'd1 ? {{24{sx_q & ld_bytes[7]}}, ld_bytes[7:0]}
               : n_q == 3'd2 ? {{16{sx_q & ld_bytes[15]}}, ld_bytes[15:0]} : ld_bytes;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            rdata_o  <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            wd_q     <= '0;
            rbuf     <= '0;
            n_q      <= '0;
            icnt     <= '0;
            rcnt     <= '0;
            t        <= '0;
            sx_q     <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
            err_o    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_i) begin
                    busy_o <= 1'b1;
                    n_q    <= n_in;
                    sx_q   <= sext_i;
                    wd_q   <= wdata_i;
                    icnt   <= 3'd1;
                    rcnt   <= '0;
                    t      <= 3'd1;
                    rbuf   <= '0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
                    if (mis) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= DONE;
                    end else
`endif
                    begin
                        mem_a  <= addr_i;
                        mem_wr <= we_i;
                        state  <= we_i ? STORE : LOAD;
                        if (we_i) mem_dout <= wdata_i[7:0];
                    end
                end
                STORE: if (icnt < n_q) begin
                    mem_a    <= mem_a + ADDR_W'(1);
                    mem_dout <= wd_q[{icnt[1:0], 3'b000} +: 8];
                    icnt     <= icnt + 3'd1;
                end else begin
                    mem_wr <= 1'b0;
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                LOAD: begin
                    t <= t + 3'd1;
                    if (icnt < n_q) begin
                        mem_a <= mem_a + ADDR_W'(1);
                        icnt  <= icnt + 3'd1;
                    end
                    if (t > LAT) begin
                        rbuf <= ld_bytes;
                        rcnt <= rcnt + 3'd1;
                        if (rcnt == n_q - 3'd1) begin
                            rdata_o <= ld_val;
                            done_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
                    err_o  <= 1'b0;
`endif
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl against a latency-1 byte RAM model.
module tb_mem_ctrl;
    logic clk = 1'b0, rst = 1'b1, req_i = 1'b0, we_i = 1'b0, sext_i = 1'b0;
    logic [1:0] size_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0, rdata_o, mem_a;
    logic busy_o, done_o, err_o, mem_wr;
    logic [7:0] mem_dout, mem_din;
    logic [7:0] ram [0:1023];
    logic [39:0] exp_wr[$], obs_wr[$];
    logic [31:0] exp_rd[$];
    int vectors = 0, miscompares = 0;

    mem_ctrl #(.ADDR_W(32), .RAM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i), .sext_i(sext_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .err_o(err_o), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
        mem_din <= ram[mem_a[9:0]];
    end

    // Drives one request, then scrambles the inputs to prove they were latched; collects writes until done_o.
    task automatic do_xfer(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                           input logic [31:0] wd, output int dc, output logic [31:0] rd,
                           output logic er, output logic bz);
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
        @(negedge clk);
        req_i = 1'b0; we_i = ~we; size_i = $urandom_range(0, 3); sext_i = ~sx;
        addr_i = $urandom; wdata_i = $urandom;
        dc = 0; rd = 'x; er = 1'bx; bz = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (mem_wr) obs_wr.push_back({mem_a, mem_dout});
            if (!busy_o) bz = 1'b0;
            if (done_o) begin
                dc = c; rd = rdata_o; er = err_o;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy_o, done_o, err_o, mem_wr} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, err_o, mem_wr});
        end
        vectors++;
        if ({rdata_o, mem_a, mem_dout} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {rdata_o, mem_a, mem_dout});
        end
        rst = 1'b0;
    endtask

    task automatic test_store_word;
        int dc; logic [31:0] rd; logic er, bz; logic [39:0] e, o;
        exp_wr.push_back({32'h100, 8'hEF}); exp_wr.push_back({32'h101, 8'hBE});
        exp_wr.push_back({32'h102, 8'hAD}); exp_wr.push_back({32'h103, 8'hDE});
        obs_wr.delete();
        do_xfer(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, dc, rd, er, bz);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.size() > 0 ? obs_wr.pop_front() : 40'hx;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL store_wr: got %h want %h", o, e);
            end
        end
        vectors++;
        if (obs_wr.size() != 0) begin
            miscompares++;
            $display("FAIL store_extra_wr: got %0d extra want 0", obs_wr.size());
        end
        vectors++;
        if (dc != 5 || bz !== 1'b1) begin
            miscompares++;
            $display("FAIL store_done: got cycle %0d busy %b want cycle 5 busy 1", dc, bz);
        end
    endtask

    task automatic test_load_word;
        int dc; logic [31:0] rd, e; logic er, bz;
        exp_rd.push_back(32'hDEADBEEF);
        obs_wr.delete();
        do_xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, dc, rd, er, bz);
        e = exp_rd.pop_front();
        vectors++;
        if (rd !== e) begin
            miscompares++;
            $display("FAIL load_word: got %h want %h", rd, e);
        end
        vectors++;
        if (dc != 6 || obs_wr.size() != 0) begin
            miscompares++;
            $display("FAIL load_timing: got cycle %0d writes %0d want cycle 6 writes 0", dc, obs_wr.size());
        end
    endtask

    task automatic test_sext;
        int dc; logic [31:0] rd, e; logic er, bz;
        do_xfer(1'b1, 2'b00, 1'b0, 32'h20, 32'h55AA_1280, dc, rd, er, bz);
        vectors++;
        if (dc != 2) begin
            miscompares++;
            $display("FAIL sb_done: got cycle %0d want 2", dc);
        end
        do_xfer(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_007F, dc, rd, er, bz);
        exp_rd.push_back(32'hFFFFFF80); exp_rd.push_back(32'h00000080); exp_rd.push_back(32'h00007F80);
        do_xfer(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, dc, rd, er, bz);
        e = exp_rd.pop_front();
        vectors++;
        if (rd !== e || dc != 3) begin
            miscompares++;
            $display("FAIL lb: got %h @%0d want %h @3", rd, dc, e);
        end
        do_xfer(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, dc, rd, er, bz);
        e = exp_rd.pop_front();
        vectors++;
        if (rd !== e) begin
            miscompares++;
            $display("FAIL lbu: got %h want %h", rd, e);
        end
        do_xfer(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, dc, rd, er, bz);
        e = exp_rd.pop_front();
        vectors++;
        if (rd !== e || dc != 4) begin
            miscompares++;
            $display("FAIL lh: got %h @%0d want %h @4", rd, dc, e);
        end
    endtask

    task automatic test_back_to_back;
        int d1 = 0, d2 = 0; logic b7 = 1'bx; logic [31:0] a8 = 'x, e;
        exp_rd.push_back(32'hDEADBEEF); exp_rd.push_back(32'hDEADBEEF);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; sext_i = 1'b0; addr_i = 32'h100;
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            if (done_o) begin
                if (d1 == 0) d1 = c; else d2 = c;
                e = exp_rd.size() > 0 ? exp_rd.pop_front() : 32'hx;
                vectors++;
                if (rdata_o !== e) begin
                    miscompares++;
                    $display("FAIL b2b_rdata: got %h want %h", rdata_o, e);
                end
            end
            if (c == 7) b7 = busy_o;
            if (c == 8) begin a8 = mem_a; req_i = 1'b0; end
            if (d2 != 0) break;
            @(negedge clk);
        end
        vectors++;
        if (d1 != 6 || d2 != 13) begin
            miscompares++;
            $display("FAIL b2b_done: got cycles %0d,%0d want 6,13", d1, d2);
        end
        vectors++;
        if (b7 !== 1'b0 || a8 !== 32'h100) begin
            miscompares++;
            $display("FAIL b2b_gap: got busy %b mem_a %h want busy 0 mem_a 00000100", b7, a8);
        end
    endtask

    task automatic test_reset_mid_store;
        int nwr = 0;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h200; wdata_i = 32'h11223344;
        @(negedge clk);
        req_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (mem_wr) nwr++;
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst = 1'b0;
                vectors++;
                if ({busy_o, done_o, err_o, mem_wr, rdata_o, mem_a, mem_dout} !== 76'h0) begin
                    miscompares++;
                    $display("FAIL rst_mid: got %h want 0", {busy_o, done_o, err_o, mem_wr, rdata_o, mem_a, mem_dout});
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (nwr != 2) begin
            miscompares++;
            $display("FAIL rst_mid_writes: got %0d want 2", nwr);
        end
    endtask

    task automatic test_misaligned;
        int dc; logic [31:0] rd; logic er, bz; logic [39:0] e, o;
        int exp_dc;
        logic exp_er;
`ifdef MEM_CTRL_ALIGN_CHK_EN
        exp_dc = 1; exp_er = 1'b1;
`else
        exp_dc = 5; exp_er = 1'b0;
        exp_wr.push_back({32'h102, 8'hEF}); exp_wr.push_back({32'h103, 8'hBE});
        exp_wr.push_back({32'h104, 8'hAD}); exp_wr.push_back({32'h105, 8'hDE});
`endif
        obs_wr.delete();
        do_xfer(1'b1, 2'b10, 1'b0, 32'h102, 32'hDEADBEEF, dc, rd, er, bz);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.size() > 0 ? obs_wr.pop_front() : 40'hx;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mis_wr: got %h want %h", o, e);
            end
        end
        vectors++;
        if (obs_wr.size() != 0 || dc != exp_dc || er !== exp_er) begin
            miscompares++;
            $display("FAIL mis_store: got extra %0d cycle %0d err %b want 0 %0d %b", obs_wr.size(), dc, er, exp_dc, exp_er);
        end
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL mis_rdata: got %h want 00000000", rd);
        end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_load_word;
        test_sext;
        test_back_to_back;
        test_reset_mid_store;
        test_misaligned;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
